// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit driving HI/LO: radix-2 shift-add multiply and
// restoring divide on magnitudes, with signs applied in a final fix-up cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   // state  | meaning
   // IDLE   | waiting for start, MTHI/MTLO writes allowed
   // PREP   | take magnitudes and result signs, clear accumulator
   // RUN    | one multiplier/quotient bit per cycle, WIDTH cycles
   // FIX    | apply signs, write HI/LO, pulse done
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]   x_q, x_d;          // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   y_q, y_d;          // multiplier or dividend magnitude, shifted out MSB first
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sign_pq_q, sign_pq_d, sign_r_q, sign_r_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dbz_q, dbz_d;

   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      x_d       = x_q;
      y_d       = y_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sign_pq_d = sign_pq_q;
      sign_r_d  = sign_r_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;
      neg_a     = ~op_q[0] & a_q[WIDTH-1];
      neg_b     = ~op_q[0] & b_q[WIDTH-1];
      mag_a     = neg_a ? -a_q : a_q;
      mag_b     = neg_b ? -b_q : b_q;
      trial     = {acc_q[2*WIDTH-1:WIDTH], y_q[WIDTH-1]};
      rem_sub   = trial[WIDTH-1:0] - x_q;
      prod      = sign_pq_q ? -acc_q : acc_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               op_d    = op_i;
               a_d     = a_i;
               b_d     = b_i;
               state_d = S_PREP;
            end else begin
               if (hi_we_i) hi_d = wdata_i;
               if (lo_we_i) lo_d = wdata_i;
            end
         end
         S_PREP: begin
            x_d       = op_q[1] ? mag_b : mag_a;
            y_d       = op_q[1] ? mag_a : mag_b;
            sign_pq_d = neg_a ^ neg_b;
            sign_r_d  = neg_a;
            acc_d     = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (op_q[1]) begin
               // restoring step: remainder in the upper half, quotient shifts into the lower half
               if (trial >= {1'b0, x_q}) begin
                  acc_d = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
                     + (y_q[WIDTH-1] ? {{WIDTH{1'b0}}, x_q} : '0);
            end
            y_d   = {y_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (!op_q[1]) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (b_q == '0) begin
               hi_d  = a_q;
               lo_d  = '1;
               dbz_d = 1'b1;
            end else begin
               lo_d = sign_pq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
               hi_d = sign_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         sign_pq_q <= 1'b0;
         sign_r_q  <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         x_q       <= x_d;
         y_q       <= y_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         sign_pq_q <= sign_pq_d;
         sign_r_q  <= sign_r_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random operations checked
// against an arithmetic reference model using 64-bit integer math.
module tb_mult_div_unit;
   localparam int W   = 32;
   localparam int LAT = W + 2;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          start_i;
   logic [1:0]    op_i;
   logic [W-1:0]  a_i, b_i, wdata_i;
   logic          hi_we_i, lo_we_i;
   logic          busy_o, done_o, div_by_zero_o;
   logic [W-1:0]  hi_o, lo_o;

   int checks   = 0;
   int failures = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
      .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
      .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
      longint     sa, sb, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      dbz = 1'b0;
      case (op)
         2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
         default: begin
            if (b == '0) begin
               hi = a; lo = '1; dbz = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; hi = r[31:0];
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endfunction

   // Called just after a rising edge; issues one operation and follows it to done.
   task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dbz,
                        input bit disturb, input bit wr_with_start);
      int          n;
      bit          busy_ok;
      logic [W-1:0] hi_before, lo_before;
      hi_before = hi_o;
      lo_before = lo_o;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      if (wr_with_start) begin lo_we_i = 1'b1; wdata_i = 32'h0000AAAA; end
      @(posedge clk_i); #1;
      start_i = 1'b0; lo_we_i = 1'b0;
      op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
      if (wr_with_start) check_eq("start_with_lo_we", lo_o, lo_before);
      busy_ok = busy_o;
      n = 0;
      while (!done_o && n < LAT + 20) begin
         if (disturb && n == 5) begin
            start_i = 1'b1; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
            hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = $urandom;
         end else begin
            start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
         end
         @(posedge clk_i); #1;
         n++;
         if (disturb && n == 6) begin
            check_eq("hi_we_busy", hi_o, hi_before);
            check_eq("lo_we_busy", lo_o, lo_before);
         end
         if (!done_o && !busy_o) busy_ok = 0;
      end
      start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
      check_eq("latency", n, LAT);
      check_eq("busy_during_op", busy_ok, 1);
      check_eq("busy_at_done", busy_o, 0);
      check_eq("hi", hi_o, exp_hi);
      check_eq("lo", lo_o, exp_lo);
      check_eq("div_by_zero", div_by_zero_o, exp_dbz);
      @(posedge clk_i); #1;
      check_eq("done_pulse_end", done_o, 0);
      check_eq("dbz_pulse_end", div_by_zero_o, 0);
      check_eq("hi_hold", hi_o, exp_hi);
   endtask

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a, b, hi, lo;
      logic         dbz;
   } vec_t;

   vec_t dir_vecs[$] = '{
      '{2'b00, 32'hFFFFFFFB, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0},
      '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
      '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0},
      '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
      '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0},
      '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0},
      '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
      '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1},
      '{2'b10, 32'hFFFF0000, 32'h00000000, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1},
      '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0}
   };

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el;
      logic         ed;
      reset_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_done", done_o, 0);
      check_eq("rst_dbz", div_by_zero_o, 0);
      check_eq("rst_hi", hi_o, 0);
      check_eq("rst_lo", lo_o, 0);
      reset_i = 1'b0;
      @(posedge clk_i); #1;

      foreach (dir_vecs[i])
         do_op(dir_vecs[i].op, dir_vecs[i].a, dir_vecs[i].b,
               dir_vecs[i].hi, dir_vecs[i].lo, dir_vecs[i].dbz, 1'b0, 1'b0);

      lo_we_i = 1'b1; wdata_i = 32'h55;
      @(posedge clk_i); #1;
      lo_we_i = 1'b0;
      check_eq("mtlo_idle", lo_o, 32'h55);
      hi_we_i = 1'b1; wdata_i = 32'h66;
      @(posedge clk_i); #1;
      hi_we_i = 1'b0;
      check_eq("mthi_idle", hi_o, 32'h66);

      do_op(2'b11, 32'd1000, 32'd9, 32'd1, 32'd111, 1'b0, 1'b1, 1'b1);

      hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEADBEEF;
      @(posedge clk_i); #1;
      hi_we_i = 1'b0; lo_we_i = 1'b0;
      start_i = 1'b1; op_i = 2'b10; a_i = 32'd12345; b_i = 32'd17;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #2 reset_i = 1'b1;
      #1;
      check_eq("midrst_busy", busy_o, 0);
      check_eq("midrst_done", done_o, 0);
      check_eq("midrst_hi", hi_o, 0);
      check_eq("midrst_lo", lo_o, 0);
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      do_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = '1;
            2:       b = $urandom_range(1, 20);
            default: b = $urandom;
         endcase
         ref_model(op, a, b, eh, el, ed);
         do_op(op, a, b, eh, el, ed, (i % 8) == 3, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
